// File: rtl/fu_arbiter.sv
// Round-robin arbiter sharing one combinational FunctionalUnit between two requesters.
// Each accepted operation runs IDLE -> ISSUE -> RESP and may update the icc register.
module fu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4,
    parameter int SW    = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req0_setcc,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    input  logic             req1_setcc,

    output logic             resp0_valid,
    output logic             resp1_valid,
    output logic [WIDTH-1:0] resp_result,
    output logic [SW-1:0]    resp_status,

    output logic [WIDTH-1:0] fu_a,
    output logic [WIDTH-1:0] fu_b,
    output logic [OPW-1:0]   fu_opcode,
    input  logic [WIDTH-1:0] fu_result,
    input  logic [SW-1:0]    fu_status,

    output logic [SW-1:0]    icc,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic               last_grant_reg;
    logic               id_reg;
    logic               setcc_reg;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [OPW-1:0]     op_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [SW-1:0]      status_reg;
    logic [SW-1:0]      icc_reg;

    logic [1:0]         req_valid;
    logic [1:0]         ready_vec;
    logic [1:0]         resp_vec;
    logic               grant;
    logic               accept;

    logic [WIDTH-1:0]   sel_a, sel_b;
    logic [OPW-1:0]     sel_op;
    logic               sel_setcc;

    assign req_valid = {req1_valid, req0_valid};

    // On a tie the requester that did not win last time gets the FU.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b10) begin
            grant = 1'b1;
        end else if (req_valid == 2'b11) begin
            grant = ~last_grant_reg;
        end
    end

    // Ready is held low during reset so no handshake can coincide with it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign ready_vec[gi] = (state_reg == IDLE) && !rst && req_valid[gi]
                                   && (grant == 1'(gi));
            assign resp_vec[gi]  = (state_reg == RESP) && (id_reg == 1'(gi));
        end
    endgenerate

    assign accept = |ready_vec;

    always_comb begin
        sel_a     = req0_a;
        sel_b     = req0_b;
        sel_op    = req0_op;
        sel_setcc = req0_setcc;
        if (grant) begin
            sel_a     = req1_a;
            sel_b     = req1_b;
            sel_op    = req1_op;
            sel_setcc = req1_setcc;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            id_reg         <= 1'b0;
            setcc_reg      <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            op_reg         <= '0;
            result_reg     <= '0;
            status_reg     <= '0;
            icc_reg        <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg          <= sel_a;
                b_reg          <= sel_b;
                op_reg         <= sel_op;
                setcc_reg      <= sel_setcc;
                id_reg         <= grant;
                last_grant_reg <= grant;
            end
            if (state_reg == ISSUE) begin
                result_reg <= fu_result;
                status_reg <= fu_status;
                if (setcc_reg) begin
                    icc_reg <= fu_status;
                end
            end
        end
    end

    // The operand latches only change on accept, so driving the FU straight
    // from them gives the latched values in ISSUE and holds them otherwise.
    assign fu_a        = a_reg;
    assign fu_b        = b_reg;
    assign fu_opcode   = op_reg;

    assign req0_ready  = ready_vec[0];
    assign req1_ready  = ready_vec[1];
    assign resp0_valid = resp_vec[0];
    assign resp1_valid = resp_vec[1];
    assign resp_result = result_reg;
    assign resp_status = status_reg;
    assign icc         = icc_reg;
    assign busy        = (state_reg != IDLE);

endmodule
